// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the RV32 core.
// Drives iaddr from the pc register, captures idata into a DEPTH-entry
// first-word-fall-through buffer and presents {pc, instr} to decode through
// a valid/ready handshake. A redirect from execute flushes the buffer and
// restarts fetch at the new target.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// to TRAP_VEC with a one-cycle trap pulse). Undefined: target[1:0] forced to 0.
module fetch_unit #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        trap
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [31:0]   pc_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   count_r;
   logic          trap_r;
   logic [31:0]   mem_pc_r    [DEPTH];
   logic [31:0]   mem_instr_r [DEPTH];

   logic          pop_s;
   logic          push_s;
   logic [31:0]   redir_pc_s;
   logic          redir_trap_s;

   // Handshake decode: a redirect suppresses the push; a pop that coincides
   // with a redirect is simply lost with the flush.
   always_comb begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      if (count_r != {(AW+1){1'b0}}) begin
         pop_s = out_ready;
      end else begin
         pop_s = 1'b0;
      end
      if (fetch_en && !redirect_valid && ((count_r < DEPTH_C) || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Redirect target selection: a misaligned target vectors to TRAP_VEC.
   always_comb begin
      redir_pc_s   = redirect_target;
      redir_trap_s = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
         redir_pc_s   = TRAP_VEC;
         redir_trap_s = 1'b1;
      end else begin
         redir_pc_s   = redirect_target;
         redir_trap_s = 1'b0;
      end
   end
`else
   logic unused_trap_s;
   assign unused_trap_s = ^{TRAP_VEC, redirect_target[1:0]};

   // Redirect target selection: low bits are dropped, no trap exists.
   always_comb begin
      redir_pc_s   = {redirect_target[31:2], 2'b00};
      redir_trap_s = 1'b0;
   end
`endif

   // Control state: pc, pointers, occupancy and the trap pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r     <= RESET_VEC;
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
         trap_r   <= 1'b0;
      end else if (redirect_valid) begin
         pc_r     <= redir_pc_s;
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
         trap_r   <= redir_trap_s;
      end else begin
         trap_r <= 1'b0;
         if (push_s) begin
            pc_r     <= pc_r + 32'd4;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Buffer storage: cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_r[i]    <= 32'd0;
            mem_instr_r[i] <= 32'd0;
         end
      end else if (push_s) begin
         mem_pc_r[wr_ptr_r]    <= pc_r;
         mem_instr_r[wr_ptr_r] <= idata;
      end
   end

   assign iaddr     = pc_r;
   assign out_valid = (count_r != {(AW+1){1'b0}});
   assign out_pc    = mem_pc_r[rd_ptr_r];
   assign out_instr = mem_instr_r[rd_ptr_r];
   assign trap      = trap_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The stimulus process drives
// inputs and runs a queue-based reference model that pushes expected
// {pc, instr} pairs; a negedge monitor compares and pops them.
module tb_fetch_unit;

   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        trap;

   int n_err    = 0;
   int n_checks = 0;

   // model state
   logic [63:0] exp_q[$];
   int          mdl_cnt  = 0;
   logic [31:0] mdl_pc   = 32'd0;
   logic        mdl_trap = 1'b0;
   logic        mon_en   = 1'b0;

   fetch_unit #(.RESET_VEC(RESET_VEC), .DEPTH(DEPTH), .TRAP_VEC(TRAP_VEC)) dut (
      .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
      .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .trap(trap)
   );

   always #5 clk = ~clk;

   // instruction memory: word i holds i
   assign idata = iaddr >> 2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model update at the clock edge, using the inputs of this cycle
   task automatic model_step();
      bit pop_m, push_m;
      if (reset) begin
         exp_q.delete(); mdl_cnt = 0; mdl_pc = RESET_VEC; mdl_trap = 1'b0;
      end else if (redirect_valid) begin
         exp_q.delete(); mdl_cnt = 0; mdl_trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_target % 4 != 0) begin
            mdl_pc = TRAP_VEC; mdl_trap = 1'b1;
         end else begin
            mdl_pc = redirect_target;
         end
`else
         mdl_pc = redirect_target - (redirect_target % 4);
`endif
      end else begin
         mdl_trap = 1'b0;
         pop_m  = (mdl_cnt > 0) && out_ready;
         push_m = fetch_en && ((mdl_cnt < DEPTH) || pop_m);
         if (pop_m) mdl_cnt--;
         if (push_m) begin
            exp_q.push_back({mdl_pc, mdl_pc / 4});
            mdl_cnt++;
            mdl_pc = mdl_pc + 32'd4;
         end
      end
   endtask

   // one clock cycle with the given inputs; returns #1 after the edge
   task automatic cyc(input logic rst, input logic fe, input logic rdy,
                      input logic rv, input logic [31:0] tgt);
      reset = rst; fetch_en = fe; out_ready = rdy;
      redirect_valid = rv; redirect_target = tgt;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // monitor: compare DUT outputs against the model, pop on accepted handshake
   always @(negedge clk) begin
      if (mon_en) begin
         chk("iaddr", iaddr, mdl_pc);
         chk("trap", 32'(trap), 32'(mdl_trap));
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            if (out_valid) begin
               chk("out_pc", out_pc, exp_q[0][63:32]);
               chk("out_instr", out_instr, exp_q[0][31:0]);
            end
            if (out_ready && !redirect_valid && !reset) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      // reset
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      mon_en = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);

      // 1: streaming, one per cycle
      repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

      // 2: back-pressure fills exactly DEPTH entries
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (6) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("full_iaddr_hold", iaddr, 32'h10);
      chk("full_head_pc", out_pc, 32'h0);
      repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

      // 3: redirect while full, pop in same cycle is discarded
      repeat (6) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
      chk("redir_valid", 32'(out_valid), 32'd0);
      chk("redir_iaddr", iaddr, 32'h200);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("redir_head_pc", out_pc, 32'h200);

      // 4: pc wraps
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      chk("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      chk("wrap_next_pc", out_pc, 32'h0);

      // 5: misaligned redirect
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign_iaddr", iaddr, 32'h100);
      chk("misalign_trap", 32'(trap), 32'd1);
`else
      chk("misalign_iaddr", iaddr, 32'h200);
      chk("misalign_trap", 32'(trap), 32'd0);
`endif
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      chk("trap_clear", 32'(trap), 32'd0);

      // 6: reset with three buffered entries
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_iaddr", iaddr, RESET_VEC);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 99) < 5),
             tgt);
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
